reg_file_sb: RTL and testbench

Parametrised successor to the single-cycle CPU register file, built for the pipelined datapath.
- Two asynchronous read ports and two write ports: main writeback plus a dedicated link write for jal.
- Optional write-to-read bypass.
- Per-register busy scoreboard with an outstanding-write counter, used by the hazard unit to stall issue.
- Sits between decode (reads, busy_set) and writeback (commits).

---
 rtl/reg_file_sb_pkg.sv | 14 +
 rtl/reg_file_sb_scoreboard.sv | 55 +++++
 rtl/reg_file_sb.sv | 104 ++++++++++
 tb/tb_reg_file_sb.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_sb_pkg.sv
// Shared CPU constants for the pipelined register file and the control unit
// that drives the link write port.
package reg_file_sb_pkg;

   localparam int unsigned REG_ZERO     = 0;
   localparam int unsigned DEF_SP_IDX   = 29;
   localparam int unsigned DEF_SP_INIT  = 128;
   localparam int unsigned DEF_LINK_IDX = 31;

   localparam logic [5:0] OP_JAL   = 6'b100111;
   localparam logic [5:0] OP_JR    = 6'b111111;
   localparam logic [5:0] FUNCT_JR = 6'b001000;

endpackage

// File: rtl/reg_file_sb_scoreboard.sv
// Per-register busy scoreboard: reservations from issue, clears from commit,
// registered busy count and the busy lookups for both read ports.
module reg_file_sb_scoreboard
   import reg_file_sb_pkg::*;
#(
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned BYPASS = 1
) (
   input  logic                   clk_i,
   input  logic                   rst_n,
   input  logic [(1<<ADDR_W)-1:0] commit_vec_i,
   input  logic                   busy_set_i,
   input  logic [ADDR_W-1:0]      busy_addr_i,
   input  logic [ADDR_W-1:0]      rs_addr_i,
   input  logic [ADDR_W-1:0]      rt_addr_i,
   output logic                   rs_busy_o,
   output logic                   rt_busy_o,
   output logic [ADDR_W:0]        busy_cnt_o
);

   localparam int unsigned NUM_REGS = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

   logic [NUM_REGS-1:0] busy_q, busy_d, set_vec;
   logic [ADDR_W:0]     cnt_q, cnt_d;

   // Set is applied after clear so a new producer outlives the retiring one.
   always_comb begin
      set_vec = '0;
      if (busy_set_i && busy_addr_i != ZERO_ADDR) set_vec[busy_addr_i] = 1'b1;
      busy_d            = (busy_q & ~commit_vec_i) | set_vec;
      busy_d[REG_ZERO]  = 1'b0;
      cnt_d = '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         cnt_d = cnt_d + {{ADDR_W{1'b0}}, busy_d[i]};
      end
   end

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= '0;
         cnt_q  <= '0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
      end
   end

   assign rs_busy_o = (rs_addr_i != ZERO_ADDR) && busy_q[rs_addr_i] &&
                      !((BYPASS != 0) && commit_vec_i[rs_addr_i]);
   assign rt_busy_o = (rt_addr_i != ZERO_ADDR) && busy_q[rt_addr_i] &&
                      !((BYPASS != 0) && commit_vec_i[rt_addr_i]);
   assign busy_cnt_o = cnt_q;

endmodule

// File: rtl/reg_file_sb.sv
// Pipelined register file: two combinational read ports, writeback and link
// write ports, optional write-to-read bypass, and a busy scoreboard.
module reg_file_sb
   import reg_file_sb_pkg::*;
#(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned SP_IDX   = DEF_SP_IDX,
   parameter int unsigned SP_INIT  = DEF_SP_INIT,
   parameter int unsigned LINK_IDX = DEF_LINK_IDX,
   parameter int unsigned BYPASS   = 1
) (
   input  logic              clk_i,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] rs_addr_i,
   input  logic [ADDR_W-1:0] rt_addr_i,
   output logic [DATA_W-1:0] rs_data_o,
   output logic [DATA_W-1:0] rt_data_o,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic              link_en_i,
   input  logic [DATA_W-1:0] link_data_i,
   input  logic              busy_set_i,
   input  logic [ADDR_W-1:0] busy_addr_i,
   output logic              rs_busy_o,
   output logic              rt_busy_o,
   output logic [ADDR_W:0]   busy_cnt_o,
   output logic              collide_o
);

   localparam int unsigned NUM_REGS = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);
   localparam logic [ADDR_W-1:0] LINK_ADDR = ADDR_W'(LINK_IDX);

   logic [DATA_W-1:0]   regs_q [NUM_REGS];
   logic [DATA_W-1:0]   regs_d [NUM_REGS];
   logic [NUM_REGS-1:0] commit_vec;
   logic                collide_q, collide_d;

   // Link is applied last so it wins a collision on LINK_IDX.
   always_comb begin
      regs_d     = regs_q;
      commit_vec = '0;
      if (wr_en_i) begin
         regs_d[wr_addr_i]     = wr_data_i;
         commit_vec[wr_addr_i] = 1'b1;
      end
      if (link_en_i) begin
         regs_d[LINK_IDX]     = link_data_i;
         commit_vec[LINK_IDX] = 1'b1;
      end
      regs_d[REG_ZERO]     = '0;
      commit_vec[REG_ZERO] = 1'b0;
      collide_d = wr_en_i && link_en_i && (wr_addr_i == LINK_ADDR);
   end

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= (i == SP_IDX) ? DATA_W'(SP_INIT) : '0;
         end
         collide_q <= 1'b0;
      end else begin
         regs_q    <= regs_d;
         collide_q <= collide_d;
      end
   end

   always_comb begin
      rs_data_o = regs_q[rs_addr_i];
      if (BYPASS != 0 && rs_addr_i != ZERO_ADDR) begin
         if (link_en_i && rs_addr_i == LINK_ADDR) rs_data_o = link_data_i;
         else if (wr_en_i && rs_addr_i == wr_addr_i) rs_data_o = wr_data_i;
      end
   end

   always_comb begin
      rt_data_o = regs_q[rt_addr_i];
      if (BYPASS != 0 && rt_addr_i != ZERO_ADDR) begin
         if (link_en_i && rt_addr_i == LINK_ADDR) rt_data_o = link_data_i;
         else if (wr_en_i && rt_addr_i == wr_addr_i) rt_data_o = wr_data_i;
      end
   end

   assign collide_o = collide_q;

   reg_file_sb_scoreboard #(
      .ADDR_W (ADDR_W),
      .BYPASS (BYPASS)
   ) u_scoreboard (
      .clk_i        (clk_i),
      .rst_n        (rst_n),
      .commit_vec_i (commit_vec),
      .busy_set_i   (busy_set_i),
      .busy_addr_i  (busy_addr_i),
      .rs_addr_i    (rs_addr_i),
      .rt_addr_i    (rt_addr_i),
      .rs_busy_o    (rs_busy_o),
      .rt_busy_o    (rt_busy_o),
      .busy_cnt_o   (busy_cnt_o)
   );

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench: one bypassing and one non-bypassing instance share the
// same stimulus; expectations are queued and drained when outputs settle.
module tb_reg_file_sb;

   logic        clk_i = 1'b0;
   logic        rst_n;
   logic [4:0]  rs_addr, rt_addr, wr_addr, busy_addr;
   logic [31:0] wr_data, link_data;
   logic        wr_en, link_en, busy_set;

   logic [31:0] rs_data1, rt_data1, rs_data0, rt_data0;
   logic        rs_busy1, rt_busy1, rs_busy0, rt_busy0;
   logic [5:0]  cnt1, cnt0;
   logic        collide1, collide0;

   typedef enum logic [3:0] {
      KRs, KRt, KRsBusy, KRtBusy, KCnt, KCollide, KRs0, KRsBusy0, KCnt0
   } kind_e;

   typedef struct {
      string       tag;
      kind_e       kind;
      logic [31:0] exp;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk_i = ~clk_i;

   reg_file_sb #(.DATA_W(32), .ADDR_W(5), .SP_IDX(29), .SP_INIT(128), .LINK_IDX(31),
                 .BYPASS(1)) u_dut1 (
      .clk_i(clk_i), .rst_n(rst_n), .rs_addr_i(rs_addr), .rt_addr_i(rt_addr),
      .rs_data_o(rs_data1), .rt_data_o(rt_data1), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
      .wr_data_i(wr_data), .link_en_i(link_en), .link_data_i(link_data),
      .busy_set_i(busy_set), .busy_addr_i(busy_addr), .rs_busy_o(rs_busy1),
      .rt_busy_o(rt_busy1), .busy_cnt_o(cnt1), .collide_o(collide1)
   );

   reg_file_sb #(.DATA_W(32), .ADDR_W(5), .SP_IDX(29), .SP_INIT(128), .LINK_IDX(31),
                 .BYPASS(0)) u_dut0 (
      .clk_i(clk_i), .rst_n(rst_n), .rs_addr_i(rs_addr), .rt_addr_i(rt_addr),
      .rs_data_o(rs_data0), .rt_data_o(rt_data0), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
      .wr_data_i(wr_data), .link_en_i(link_en), .link_data_i(link_data),
      .busy_set_i(busy_set), .busy_addr_i(busy_addr), .rs_busy_o(rs_busy0),
      .rt_busy_o(rt_busy0), .busy_cnt_o(cnt0), .collide_o(collide0)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic push(input string tag, input kind_e kind, input logic [31:0] exp);
      exp_t e;
      e.tag  = tag;
      e.kind = kind;
      e.exp  = exp;
      exp_q.push_back(e);
   endtask

   // Let combinational outputs settle, then compare every queued expectation.
   task automatic drain();
      exp_t        e;
      logic [31:0] obs;
      #1;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         case (e.kind)
            KRs:      obs = rs_data1;
            KRt:      obs = rt_data1;
            KRsBusy:  obs = {31'd0, rs_busy1};
            KRtBusy:  obs = {31'd0, rt_busy1};
            KCnt:     obs = {26'd0, cnt1};
            KCollide: obs = {31'd0, collide1};
            KRs0:     obs = rs_data0;
            KRsBusy0: obs = {31'd0, rs_busy0};
            KCnt0:    obs = {26'd0, cnt0};
            default:  obs = 'x;
         endcase
         check_eq(e.tag, obs, e.exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
      wr_en    = 1'b0;
      link_en  = 1'b0;
      busy_set = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; wr_en = 1'b0; link_en = 1'b0; busy_set = 1'b0;
      rs_addr = '0; rt_addr = '0; wr_addr = '0; busy_addr = '0;
      wr_data = '0; link_data = '0;
      #12;
      rs_addr = 5'd29; rt_addr = 5'd5;
      push("rst_sp", KRs, 32'd128);
      push("rst_rt", KRt, 32'd0);
      push("rst_cnt", KCnt, 32'd0);
      push("rst_collide", KCollide, 32'd0);
      push("rst_sp_nobyp", KRs0, 32'd128);
      drain();
      rst_n = 1'b1;
      step();

      // Write with same-cycle read
      wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hDEADBEEF; rs_addr = 5'd7;
      push("byp_pre", KRs, 32'hDEADBEEF);
      push("nobyp_pre", KRs0, 32'd0);
      drain();
      step();
      push("byp_post", KRs, 32'hDEADBEEF);
      push("nobyp_post", KRs0, 32'hDEADBEEF);
      drain();

      // Register zero ignores writes
      wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234; rs_addr = 5'd0;
      push("r0_pre", KRs, 32'd0);
      drain();
      step();
      push("r0_post", KRs, 32'd0);
      push("r0_post_nobyp", KRs0, 32'd0);
      drain();

      // Link collision
      link_en = 1'b1; link_data = 32'h40; wr_en = 1'b1; wr_addr = 5'd31; wr_data = 32'h99;
      rs_addr = 5'd31; rt_addr = 5'd31;
      push("coll_byp", KRs, 32'h40);
      push("coll_nobyp", KRs0, 32'd0);
      push("coll_pre", KCollide, 32'd0);
      drain();
      step();
      push("coll_r31", KRs, 32'h40);
      push("coll_r31_nobyp", KRs0, 32'h40);
      push("coll_pulse", KCollide, 32'd1);
      drain();
      step();
      push("coll_clear", KCollide, 32'd0);
      drain();

      // Distinct targets both commit
      link_en = 1'b1; link_data = 32'h44; wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'h55;
      step();
      rs_addr = 5'd31; rt_addr = 5'd12;
      push("dual_link", KRs, 32'h44);
      push("dual_wb", KRt, 32'h55);
      push("dual_nocoll", KCollide, 32'd0);
      drain();

      // Scoreboard counting
      busy_set = 1'b1; busy_addr = 5'd3;
      step();
      push("cnt_1", KCnt, 32'd1);
      drain();
      busy_set = 1'b1; busy_addr = 5'd5;
      step();
      push("cnt_2", KCnt, 32'd2);
      drain();
      busy_set = 1'b1; busy_addr = 5'd3;
      step();
      rs_addr = 5'd3; rt_addr = 5'd5;
      push("cnt_nodouble", KCnt, 32'd2);
      push("rs_busy3", KRsBusy, 32'd1);
      push("rt_busy5", KRtBusy, 32'd1);
      drain();

      // Commit to 3 hides busy in the commit cycle only when bypassing
      wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h33;
      push("busy_commit_byp", KRsBusy, 32'd0);
      push("busy_commit_nobyp", KRsBusy0, 32'd1);
      drain();
      step();
      push("cnt_after_commit", KCnt, 32'd1);
      push("busy3_clear", KRsBusy, 32'd0);
      drain();

      // Set/clear race on the same register
      busy_set = 1'b1; busy_addr = 5'd9; wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
      step();
      rs_addr = 5'd9;
      push("race_busy", KRsBusy, 32'd1);
      push("race_data", KRs, 32'h99);
      push("race_cnt", KCnt, 32'd2);
      drain();
      busy_set = 1'b1; busy_addr = 5'd0;
      step();
      rs_addr = 5'd0;
      push("set0_cnt", KCnt, 32'd2);
      push("set0_busy", KRsBusy, 32'd0);
      drain();

      // Fill to four, then reset mid-cycle
      busy_set = 1'b1; busy_addr = 5'd20;
      step();
      busy_set = 1'b1; busy_addr = 5'd21;
      step();
      push("cnt_4", KCnt, 32'd4);
      push("cnt_4_nobyp", KCnt0, 32'd4);
      drain();
      #2;
      rst_n = 1'b0;
      rs_addr = 5'd29; rt_addr = 5'd5;
      push("rst2_cnt", KCnt, 32'd0);
      push("rst2_sp", KRs, 32'd128);
      push("rst2_busy5", KRtBusy, 32'd0);
      push("rst2_collide", KCollide, 32'd0);
      drain();
      rst_n = 1'b1;
      step();
      rs_addr = 5'd7;
      push("rst2_r7", KRs, 32'd0);
      push("rst2_cnt_hold", KCnt, 32'd0);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
